// File: rtl/mlp_io_pkg.sv
// Shared types and defaults for the MLP sample packer: state encoding,
// default widths and the settle-counter width helper.
package mlp_io_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    SETTLE  = 2'd1,
    RESULT  = 2'd2
  } state_t;

  localparam int DEF_NUM_A         = 4;
  localparam int DEF_WIDTH_A       = 4;
  localparam int DEF_OUTWIDTH      = 2;
  localparam int DEF_SETTLE_CYCLES = 4;

  // Counter must be able to hold SETTLE_CYCLES-1 even for SETTLE_CYCLES==1.
  function automatic int settle_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/mlp_settle_timer.sv
// Load/decrement down-counter; done is high while the count is zero.
module mlp_settle_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] cnt_r;

  // Counter register: load wins over decrement, saturates at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != {W{1'b0}})) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/mlp_sample_packer.sv
// Packs NUM_A feature beats into the classifier inp bus, waits SETTLE_CYCLES and
// returns the class index. Optional framing check: define MLP_FRAME_CHECK_EN.
module mlp_sample_packer
  import mlp_io_pkg::*;
#(
  parameter int NUM_A         = DEF_NUM_A,
  parameter int WIDTH_A       = DEF_WIDTH_A,
  parameter int OUTWIDTH      = DEF_OUTWIDTH,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH_A-1:0]       s_data,
  input  logic                     s_last,
  output logic [NUM_A*WIDTH_A-1:0] inp,
  input  logic [OUTWIDTH-1:0]      cls_out,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [OUTWIDTH-1:0]      m_data,
  output logic                     frame_err
);

  localparam int SETTLE_W = settle_w(SETTLE_CYCLES);
  localparam int IDX_W    = (NUM_A > 1) ? $clog2(NUM_A) : 1;

  state_t                     state_r;
  logic [IDX_W-1:0]           idx_r;
  logic [NUM_A*WIDTH_A-1:0]   shadow_r;
  logic [NUM_A*WIDTH_A-1:0]   packed_s;
  logic                       accept_s;
  logic                       last_beat_s;
  logic                       viol_s;
  logic                       load_s;
  logic                       done_s;

  assign s_ready     = (state_r == COLLECT);
  assign accept_s    = s_valid && s_ready;
  assign last_beat_s = (idx_r == IDX_W'(NUM_A - 1));
  assign load_s      = accept_s && last_beat_s && !viol_s;

`ifdef MLP_FRAME_CHECK_EN
  assign viol_s = (s_last != last_beat_s);
`else
  // s_last carries no meaning without the framing check.
  assign viol_s = s_last & 1'b0;
`endif

  // Full sample view: shadow slots with the final beat dropped into the top slot.
  always_comb begin
    packed_s = shadow_r;
    packed_s[(NUM_A-1)*WIDTH_A +: WIDTH_A] = s_data;
  end

  mlp_settle_timer #(
    .W(SETTLE_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load_s),
    .load_val (SETTLE_W'(SETTLE_CYCLES - 1)),
    .dec      (state_r == SETTLE),
    .done     (done_s)
  );

  // Control FSM with registered datapath outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= COLLECT;
      idx_r     <= {IDX_W{1'b0}};
      shadow_r  <= {(NUM_A*WIDTH_A){1'b0}};
      inp       <= {(NUM_A*WIDTH_A){1'b0}};
      m_valid   <= 1'b0;
      m_data    <= {OUTWIDTH{1'b0}};
      frame_err <= 1'b0;
    end else begin
      frame_err <= accept_s && viol_s;
      case (state_r)
        COLLECT: begin
          if (accept_s) begin
            if (viol_s) begin
              idx_r <= {IDX_W{1'b0}};
            end else if (last_beat_s) begin
              shadow_r[idx_r*WIDTH_A +: WIDTH_A] <= s_data;
              inp     <= packed_s;
              idx_r   <= {IDX_W{1'b0}};
              state_r <= SETTLE;
            end else begin
              shadow_r[idx_r*WIDTH_A +: WIDTH_A] <= s_data;
              idx_r <= idx_r + IDX_W'(1);
            end
          end
        end
        SETTLE: begin
          if (done_s) begin
            m_data  <= cls_out;
            m_valid <= 1'b1;
            state_r <= RESULT;
          end
        end
        RESULT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state_r <= COLLECT;
          end
        end
        default: begin
          state_r <= COLLECT;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mlp_sample_packer.md
# mlp_sample_packer

Synthesizable front/back end for the bespoke MLP classifiers. It accepts one sample as a stream of `NUM_A` feature beats over a valid/ready handshake and packs the beats into the classifier's flat `inp` bus. It then waits a fixed settle time for the combinational network, captures the class index and returns it over a second valid/ready handshake. It sits between an on-chip sensor/host interface and the classifier `top`, and replaces file-driven stimulus in silicon and FPGA bring-up.

## Interface
- `NUM_A`, 4: features per sample.
- `WIDTH_A`, 4: bits per feature.
- `OUTWIDTH`, 2: class index width.
- `SETTLE_CYCLES`, 4: clock cycles allowed for classifier propagation; must be ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `s_valid` in 1: feature beat valid.
- `s_ready` out 1: packer can accept a beat.
- `s_data` in `WIDTH_A`: feature value, unsigned.
- `s_last` in 1: marks the final feature of a sample.
- `inp` out `NUM_A*WIDTH_A`: registered packed features to the classifier.
- `cls_out` in `OUTWIDTH`: classifier result, combinational from `inp`.
- `m_valid` out 1: result valid.
- `m_ready` in 1: result consumer ready.
- `m_data` out `OUTWIDTH`: captured class index.
- `frame_err` out 1: one-cycle pulse on a framing violation.

## Operation
- FSM states: COLLECT, SETTLE, RESULT. Reset enters COLLECT.
- `s_ready` = (state==COLLECT). It is combinational from state, so it reads 1 in the first cycle after reset is released.
- **COLLECT:**
  - Each accepted beat (`s_valid && s_ready`) writes `s_data` into shadow slot `idx`.
  - `idx` increments, with width `$clog2(NUM_A)`.
  - Slot `i` maps to `inp[(i+1)*WIDTH_A-1 : i*WIDTH_A]`. Feature 0 occupies the LSBs.
- **Completing a sample:** on the beat with `idx==NUM_A-1`:
  - `inp` loads the shadow slots together with that beat, atomically.
  - `idx` clears.
  - The settle counter loads `SETTLE_CYCLES-1`.
  - State goes to SETTLE.
  - `inp` never shows a partial sample.
- **SETTLE:** the counter decrements each cycle. At 0, `m_data` captures `cls_out`, `m_valid` is set, and state goes to RESULT.
- **RESULT:**
  - `m_valid` and `m_data` hold until `m_valid && m_ready`.
  - On that edge, `m_valid` clears and state returns to COLLECT.
  - `inp` holds its last sample until the next sample completes.
- `s_valid` outside COLLECT is ignored: no beat is taken.
- Reset mid-operation discards the partial sample and any pending result. All outputs return to reset values.

## Timing
- Reset values: `inp`=0, `m_valid`=0, `m_data`=0, `frame_err`=0, `idx`=0, counter=0.
- Final beat accepted at edge k:
  - `inp` is valid after edge k.
  - `cls_out` is sampled at edge k+`SETTLE_CYCLES`.
  - `m_valid` is high after that edge.
- Latency:
  - Minimum throughput is `NUM_A+SETTLE_CYCLES+1` cycles per sample when `m_ready` is held 1.
  - With `m_ready`=1 the result handshake completes one cycle after `m_valid` rises.
  - `s_ready` is high the cycle after that handshake.
- `m_data` is stable while `m_valid`=1, regardless of `cls_out`.

## Configuration
- `MLP_FRAME_CHECK_EN` defined:
  - `s_last`=1 on a beat with `idx<NUM_A-1`, or `s_last`=0 on the beat with `idx==NUM_A-1`, is a framing violation.
  - The violating beat is consumed and the sample is discarded: `inp` unchanged, `idx` cleared, state stays COLLECT.
  - `frame_err` pulses 1 cycle after that edge.
- Not defined: `s_last` is ignored, `frame_err` is tied 0, and samples complete purely on beat count.

## Structure
- Package `mlp_io_pkg` holds:
  - the state enum;
  - the default width parameters (`NUM_A`, `WIDTH_A`, `OUTWIDTH`);
  - a `SETTLE_W = $clog2(SETTLE_CYCLES+1)` helper.
- One sub-module, `mlp_settle_timer`, is natural: a load/decrement down-counter with a `done` flag.

## Test plan
- Reset, then beats 3,7,0,15 with `s_last` on the 4th, `cls_out`=2'd2, `m_ready`=1 → `inp`=16'hF073 after beat 4. `m_valid` rises exactly 4 cycles later with `m_data`=2, and `s_ready` returns 1 cycle after the handshake.
- Same sample with `m_ready`=0 for 10 cycles while `cls_out` toggles → `m_valid` and `m_data`=2 are held, and `s_valid` beats are not accepted (`s_ready`=0).
- `s_valid` gaps between beats 2 and 3 → `inp` unchanged until beat 4, then correct packing.
- With `MLP_FRAME_CHECK_EN`, `s_last` on beat 2 → `frame_err` pulses once, `inp` keeps its previous value, and the next 4-beat sample packs correctly from slot 0.
- `rst_n`=0 for 1 cycle during SETTLE → no `m_valid`, `inp`=0, and `s_ready`=1 after release.
- Back-to-back samples 1,2,3,4 then 4,3,2,1 → `inp`=16'h4321 then 16'h1234, with one result per sample in order.
